// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcode and
// extension fields, branch condition codes and ALU flag bit positions.
package instr_sequencer_pkg;

  // State codes are visible on the state port, so the values are fixed.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StLdAddr = 3'd3,
    StLdWb   = 3'd4,
    StStore  = 3'd5,
    StBranch = 3'd6,
    StHalt   = 3'd7
  } state_e;

  // Opcode field ir[15:12]
  localparam logic [3:0] OpAluReg = 4'b0000;
  localparam logic [3:0] OpExt    = 4'b0100;
  localparam logic [3:0] OpBranch = 4'b1100;

  // Extension field ir[7:4] under OpExt
  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStore = 4'b0100;
  localparam logic [3:0] ExtHalt  = 4'b1111;

  // Branch condition field ir[11:8]
  localparam logic [3:0] CondZ      = 4'b0000;
  localparam logic [3:0] CondNz     = 4'b0001;
  localparam logic [3:0] CondC      = 4'b0010;
  localparam logic [3:0] CondNc     = 4'b0011;
  localparam logic [3:0] CondL      = 4'b0100;
  localparam logic [3:0] CondNl     = 4'b0101;
  localparam logic [3:0] CondN      = 4'b0110;
  localparam logic [3:0] CondNn     = 4'b0111;
  localparam logic [3:0] CondF      = 4'b1000;
  localparam logic [3:0] CondNf     = 4'b1001;
  localparam logic [3:0] CondAlways = 4'b1110;

  // Flag register layout {C,L,F,Z,N}
  localparam int unsigned FlagC = 4;
  localparam int unsigned FlagL = 3;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 0;

  // Evaluate a branch condition against the current flags; unlisted codes never take.
  function automatic logic cond_taken(input logic [3:0] cond, input logic [4:0] flags);
    logic taken;
    taken = 1'b0;
    case (cond)
      CondZ:      taken = flags[FlagZ];
      CondNz:     taken = ~flags[FlagZ];
      CondC:      taken = flags[FlagC];
      CondNc:     taken = ~flags[FlagC];
      CondL:      taken = flags[FlagL];
      CondNl:     taken = ~flags[FlagL];
      CondN:      taken = flags[FlagN];
      CondNn:     taken = ~flags[FlagN];
      CondF:      taken = flags[FlagF];
      CondNf:     taken = ~flags[FlagF];
      CondAlways: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/reg_en_decoder.sv
// 4-to-16 one-hot register-write enable decoder with a global enable.
module reg_en_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  // Single set bit at sel when enabled, all zero otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches, decodes and steps ALU, load,
// store and branch instructions, driving Moore control outputs from state/ir.
// Optional feature: define CTRL_HALT_EN to make ext opcode 0100/1111 a HALT
// that only reset can leave; otherwise that encoding executes as a NOP.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic [4:0]  flags,
  output logic [15:0] ir,
  output logic [3:0]  mux_A_sel,
  output logic [3:0]  mux_B_sel,
  output logic [15:0] reg_en,
  output logic        imm_sel,
  output logic        flag_en,
  output logic        pc_en,
  output logic        pc_ld,
  output logic        mem_w_en_a,
  output logic        addr_sel,
  output logic        wb_sel,
  output logic [15:0] br_disp,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        dec_en;

  // State and instruction register; async reset lands in FETCH with ir cleared,
  // which makes every control output zero without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state decode and Moore control outputs.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imm_sel    = 1'b0;
    flag_en    = 1'b0;
    pc_en      = 1'b0;
    pc_ld      = 1'b0;
    mem_w_en_a = 1'b0;
    addr_sel   = 1'b0;
    wb_sel     = 1'b0;
    dec_en     = 1'b0;
    unique case (state_q)
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        // Memory read data for the PC address is valid now.
        ir_d = mem_data;
        if (mem_data[15:12] == OpExt) begin
          if (mem_data[7:4] == ExtLoad) begin
            state_d = StLdAddr;
          end else if (mem_data[7:4] == ExtStore) begin
            state_d = StStore;
`ifdef CTRL_HALT_EN
          end else if (mem_data[7:4] == ExtHalt) begin
            state_d = StHalt;
`endif
          end else begin
            state_d = StExec;
          end
        end else if (mem_data[15:12] == OpBranch) begin
          state_d = StBranch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        pc_en = 1'b1;
        // Any ext opcode that reaches EXEC is a NOP: advance PC only.
        if (ir_q[15:12] != OpExt) begin
          dec_en  = 1'b1;
          flag_en = 1'b1;
          imm_sel = (ir_q[15:12] != OpAluReg);
        end
        state_d = StFetch;
      end
      StLdAddr: begin
        addr_sel = 1'b1;
        state_d  = StLdWb;
      end
      StLdWb: begin
        addr_sel = 1'b1;
        wb_sel   = 1'b1;
        dec_en   = 1'b1;
        pc_en    = 1'b1;
        state_d  = StFetch;
      end
      StStore: begin
        addr_sel   = 1'b1;
        mem_w_en_a = 1'b1;
        pc_en      = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        if (cond_taken(ir_q[11:8], flags)) begin
          pc_ld = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  reg_en_decoder u_reg_en_decoder (
    .en     (dec_en),
    .sel    (ir_q[11:8]),
    .onehot (reg_en)
  );

  assign ir        = ir_q;
  assign mux_A_sel = ir_q[11:8];
  assign mux_B_sel = ir_q[3:0];
  assign br_disp   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign state     = state_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: mem_data  in  16  memory port A read data, valid one cycle after address.
REQ-004 SHALL have: flags  in  5  ALU flag register {C,L,F,Z,N}, bit 4 = C.
REQ-005 SHALL have: ir  out  16  instruction register.
REQ-006 SHALL have: mux_A_sel, mux_B_sel  out  4 each  = ir[11:8], ir[3:0].
REQ-007 SHALL have: reg_en  out  16  one-hot register-write enable, else 0.
REQ-008 SHALL have: imm_sel, flag_en, pc_en, pc_ld, mem_w_en_a  out  1 each  (immediate operand; flag write; PC+1; PC load PC+br_disp; store strobe).
REQ-009 SHALL have: addr_sel  out  1  (0 = PC, 1 = register B drives memory address); wb_sel  out  1  (0 = ALU, 1 = mem_data to register bank).
REQ-010 SHALL have: br_disp  out  16  sign-extended ir[7:0]; state  out  3  current state code.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, LD_ADDR, LD_WB, STORE, BRANCH, HALT; every output is a Moore function of state and ir.
REQ-012 FETCH: addr_sel=0, all enables 0; next DECODE.
REQ-013 DECODE: ir <= mem_data at end of cycle; next state decoded from mem_data: opcode[15:12]=0100/ext[7:4]=0000 -> LD_ADDR; 0100/0100 -> STORE; 1100 -> BRANCH; other 0100 ext -> EXEC as NOP; else EXEC.
REQ-014 EXEC: opcode 0000 -> imm_sel=0; other non-0100 -> imm_sel=1; reg_en=onehot(ir[11:8]), flag_en=1, pc_en=1; NOP -> only pc_en=1; next FETCH (3 cycles/ALU instruction).
REQ-015 LD_ADDR: addr_sel=1, enables 0; LD_WB: addr_sel=1, wb_sel=1, reg_en=onehot(ir[11:8]), pc_en=1, flag_en=0; then FETCH (4 cycles).
REQ-016 STORE: addr_sel=1, mem_w_en_a=1 for exactly one cycle, pc_en=1, reg_en=0; next FETCH.
REQ-017 BRANCH: cond=ir[11:8]; taken -> pc_ld=1, pc_en=0; not taken -> pc_en=1, pc_ld=0; next FETCH.
REQ-018 Conditions: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1110 always; all others never taken.
REQ-019 pc_en and pc_ld SHALL never be 1 together; at most one of reg_en bits, mem_w_en_a SHALL be active.
REQ-020 br_disp = {{8{ir[7]}}, ir[7:0]}; 16-bit two's complement, PC wrap handled by PC.

Reset
REQ-021 reset=0 SHALL immediately force state FETCH, ir=16'h0000, all enables/selects 0, regardless of state.
REQ-022 Reset mid-STORE or mid-LD_WB SHALL abort the write; first cycle after release is FETCH.

Configuration
REQ-023 CTRL_HALT_EN defined: DECODE of 0100/ext 1111 -> HALT, all enables 0, exit only by reset; undefined: that encoding is a NOP and HALT is unreachable (state code reserved).

Structure
REQ-024 Shared package SHALL hold state encoding (FETCH=0 ... HALT=7), opcode/ext constants, condition codes, flag bit indices.
REQ-025 One sub-module reg_en_decoder SHALL produce the 4-to-16 one-hot with a global enable input.

Verification
REQ-026 ADD r3,r5 (16'h0355) fetched -> DECODE, EXEC with reg_en=16'h0008, flag_en=1, pc_en=1, imm_sel=0; back to FETCH after 3 cycles.
REQ-027 LOAD r2,(r7) (16'h4207) -> LD_ADDR addr_sel=1, LD_WB wb_sel=1, reg_en=16'h0004; 4 cycles total.
REQ-028 STOR (16'h4441) -> mem_w_en_a high exactly one cycle, reg_en=0, pc_en=1.
REQ-029 BEQ disp -2 (16'hC0FE) with Z=1 -> pc_ld=1, br_disp=16'hFFFE; with Z=0 -> pc_en=1, pc_ld=0.
REQ-030 reset low during STORE -> mem_w_en_a=0 immediately; after release state=FETCH, ir=0.
REQ-031 With CTRL_HALT_EN, 16'h40F0 -> HALT, no enables for 20 cycles until reset; without it -> NOP, pc_en=1.
